// File: rtl/mips_pkg.sv
// mips_pkg: constants shared across the MIPS CPU pipeline stages.
//   DATA_WIDTH_DEFAULT / ADDR_WIDTH_DEFAULT : default widths matching instructionmemory
//   RESET_ADDR_DEFAULT                       : first word address fetched after reset
//   NOP                                      : all-zero encoding decode uses for empty slots
package mips_pkg;

    localparam int DATA_WIDTH_DEFAULT = 32;
    localparam int ADDR_WIDTH_DEFAULT = 10;
    localparam int RESET_ADDR_DEFAULT = 0;

    localparam logic [31:0] NOP = 32'h0000_0000;

endpackage : mips_pkg

// File: rtl/fetch_perf_cnt.sv
// fetch_perf_cnt: free-running event counter that wraps silently.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset, clears the count
//   en_i    : count one event this cycle
//   count_o : current count (registered)
module fetch_perf_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    // Event counter; reset has priority over counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + WIDTH'(1);
        end else begin
            count_q <= count_q;
        end
    end

    assign count_o = count_q;

endmodule : fetch_perf_cnt

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the IF/ID register of the MIPS CPU.
// Drives instructionmemory's word address and captures its 1-cycle-latency data.
// Optional macro FETCH_PERF_CNT_EN adds fetch/redirect performance counters.
//   clk, rst        : clock and synchronous active-high reset
//   stall           : decode not accepting; output register and fetch state hold
//   redirect        : branch/jump taken; flushes in-flight fetches (wins over stall)
//   redirect_addr   : target word address
//   ADDR_Prog       : word address to instructionmemory
//   mem_data        : instructionmemory.dataOut (word for last cycle's address)
//   instr_out       : fetched instruction
//   pc_out          : word address of instr_out
//   instr_valid     : instr_out/pc_out hold a real instruction
//   fetch_count     : (FETCH_PERF_CNT_EN) accepted instructions
//   redirect_count  : (FETCH_PERF_CNT_EN) cycles with redirect high outside reset
module fetch_unit
    import mips_pkg::*;
#(
    parameter int data_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int RESET_ADDR = RESET_ADDR_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic [ADDR_WIDTH-1:0] ADDR_Prog,
    input  logic [data_WIDTH-1:0] mem_data,
    output logic [data_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  instr_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           fetch_count,
    output logic [31:0]           redirect_count
`endif
);

    // pc: next address to issue; inf_*: request whose data is on mem_data now
    logic [ADDR_WIDTH-1:0] pc_q,       pc_d;
    logic [ADDR_WIDTH-1:0] inf_pc_q,   inf_pc_d;
    logic                  inf_valid_q, inf_valid_d;
    logic [data_WIDTH-1:0] instr_q,    instr_d;
    logic [ADDR_WIDTH-1:0] pc_out_q,   pc_out_d;
    logic                  valid_q,    valid_d;

    // Address mux: while stalled, re-issue the in-flight address so mem_data
    // still carries that word when the stall lifts.
    always_comb begin
        if (stall && !redirect) begin
            ADDR_Prog = inf_pc_q;
        end else begin
            ADDR_Prog = pc_q;
        end
    end

    // Next-state logic: redirect beats stall; stall freezes everything.
    always_comb begin
        pc_d        = pc_q;
        inf_pc_d    = inf_pc_q;
        inf_valid_d = inf_valid_q;
        instr_d     = instr_q;
        pc_out_d    = pc_out_q;
        valid_d     = valid_q;
        if (redirect) begin
            // Flush both the in-flight slot and the output slot; instr/pc_out hold.
            pc_d        = redirect_addr;
            inf_valid_d = 1'b0;
            valid_d     = 1'b0;
        end else if (stall) begin
            pc_d        = pc_q;
            inf_valid_d = inf_valid_q;
            valid_d     = valid_q;
        end else begin
            instr_d     = mem_data;
            pc_out_d    = inf_pc_q;
            valid_d     = inf_valid_q;
            inf_pc_d    = pc_q;
            inf_valid_d = 1'b1;
            // Modulo 2^ADDR_WIDTH increment: wraps to 0 without a flag.
            pc_d        = pc_q + ADDR_WIDTH'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= ADDR_WIDTH'(RESET_ADDR);
            inf_pc_q    <= '0;
            inf_valid_q <= 1'b0;
            instr_q     <= data_WIDTH'(NOP);
            pc_out_q    <= '0;
            valid_q     <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            inf_pc_q    <= inf_pc_d;
            inf_valid_q <= inf_valid_d;
            instr_q     <= instr_d;
            pc_out_q    <= pc_out_d;
            valid_q     <= valid_d;
        end
    end

    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic accept_s;

    assign accept_s = valid_q && !stall;

    fetch_perf_cnt #(.WIDTH(32)) u_fetch_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (accept_s),
        .count_o (fetch_count)
    );

    fetch_perf_cnt #(.WIDTH(32)) u_redirect_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (redirect),
        .count_o (redirect_count)
    );
`endif

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a 1-cycle synchronous
// memory model holding mem[i] = 32'h1000_0000 + i.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [9:0]  redirect_addr;
    logic [9:0]  addr_prog;
    logic [31:0] mem_data = 32'h0;
    logic [31:0] instr_out;
    logic [9:0]  pc_out;
    logic        instr_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] redirect_count;
`endif

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .ADDR_Prog     (addr_prog),
        .mem_data      (mem_data),
        .instr_out     (instr_out),
        .pc_out        (pc_out),
        .instr_valid   (instr_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count   (fetch_count),
        .redirect_count(redirect_count)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory: synchronous read, one cycle latency.
    always @(posedge clk) mem_data <= 32'h1000_0000 + {22'h0, addr_prog};

    typedef struct { int pc; logic [31:0] instr; } item_t;
    item_t sb[$];

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    // Reference model: after reset/redirect to A the delivered stream is
    // A, A+1, ... (mod 1024); the first word becomes visible after two
    // non-stalled cycles, then one new word per non-stalled cycle.
    int warm = 2;
    int next_addr = 0;
    int acc_cnt = 0;
    int redir_cnt = 0;

    logic       cur_rst, cur_stall, cur_redir;
    logic [9:0] cur_ra;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic rd, input logic [9:0] ra);
        rst = r; stall = s; redirect = rd; redirect_addr = ra;
        cur_rst = r; cur_stall = s; cur_redir = rd; cur_ra = ra;
        #1;
    endtask

    task automatic step();
        item_t it;
        @(posedge clk);
        if (cur_rst) begin
            sb.delete(); warm = 2; next_addr = 0; acc_cnt = 0; redir_cnt = 0;
        end else if (cur_redir) begin
            sb.delete(); warm = 2; next_addr = int'(cur_ra); redir_cnt++;
        end else if (!cur_stall) begin
            if (warm > 1) begin
                warm--;
            end else begin
                warm = 0;
                it.pc = next_addr;
                it.instr = 32'h1000_0000 + next_addr;
                sb.push_back(it);
                next_addr = (next_addr + 1) % 1024;
            end
        end
        #1;
    endtask

    // Monitor: every cycle, the DUT's valid must match the model's pending
    // entry; an accepted instruction is popped and compared.
    always @(negedge clk) begin
        if (mon_en) begin
`ifdef FETCH_PERF_CNT_EN
            chk("fetch_count", fetch_count, acc_cnt);
            chk("redirect_count", redirect_count, redir_cnt);
`endif
            chk("valid", {31'h0, instr_valid}, {31'h0, sb.size() > 0});
            if (instr_valid && sb.size() > 0) begin
                chk("pc_out", {22'h0, pc_out}, sb[0].pc);
                chk("instr_out", instr_out, sb[0].instr);
                if (!stall) begin
                    void'(sb.pop_front());
                    acc_cnt++;
                end
            end
        end
    end

    task automatic redirect_check(input logic st, input logic [9:0] tgt);
        drive(1'b0, st, 1'b1, tgt);
        step();
        drive(1'b0, 1'b0, 1'b0, 10'h0);
        chk("redir_addr_n1", {22'h0, addr_prog}, {22'h0, tgt});
        chk("redir_valid_n1", {31'h0, instr_valid}, 32'h0);
        step();
        chk("redir_valid_n2", {31'h0, instr_valid}, 32'h0);
        step();
        chk("redir_valid_n3", {31'h0, instr_valid}, 32'h1);
        chk("redir_pc_n3", {22'h0, pc_out}, {22'h0, tgt});
        chk("redir_instr_n3", instr_out, 32'h1000_0000 + {22'h0, tgt});
    endtask

    task automatic run_to_pc(input logic [9:0] target, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (instr_valid && pc_out == target) hit = 1'b1;
            else step();
        end
        chk(name, {31'h0, hit}, 32'h1);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 10'h0);
        step(); step();
        // Reset state
        chk("rst_addr", {22'h0, addr_prog}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instr_out, 32'h0);
        chk("rst_pc", {22'h0, pc_out}, 32'h0);
        mon_en = 1'b1;

        // Startup latency: two cycles, then mem[0]
        drive(1'b0, 1'b0, 1'b0, 10'h0);
        step();
        chk("start_valid_e0", {31'h0, instr_valid}, 32'h0);
        step();
        chk("start_valid_e1", {31'h0, instr_valid}, 32'h1);
        chk("start_instr", instr_out, 32'h1000_0000);

        // Stall 3 cycles at pc_out=5
        run_to_pc(10'd5, "reach_pc5");
        drive(1'b0, 1'b1, 1'b0, 10'h0);
        chk("stall_replay_addr", {22'h0, addr_prog}, 32'd6);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold_instr", instr_out, 32'h1000_0005);
        end
        drive(1'b0, 1'b0, 1'b0, 10'h0);
        step();
        chk("post_stall_instr", instr_out, 32'h1000_0006);

        // Redirects: plain, together with stall, and across the wrap
        redirect_check(1'b0, 10'h200);
        for (int i = 0; i < 3; i++) step();
        redirect_check(1'b1, 10'h200);
        redirect_check(1'b0, 10'h3FE);
        for (int i = 0; i < 3; i++) step();
        chk("wrap_pc", {22'h0, pc_out}, 32'h1);

        // One-cycle reset mid-stream at pc_out=7
        drive(1'b0, 1'b0, 1'b1, 10'h0);
        step();
        drive(1'b0, 1'b0, 1'b0, 10'h0);
        run_to_pc(10'd7, "reach_pc7");
        drive(1'b1, 1'b0, 1'b0, 10'h0);
        step();
        drive(1'b0, 1'b0, 1'b0, 10'h0);
        chk("midrst_valid", {31'h0, instr_valid}, 32'h0);
        step(); step();
        chk("midrst_restart_pc", {22'h0, pc_out}, 32'h0);
        chk("midrst_restart_instr", instr_out, 32'h1000_0000);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic       r, s, rd;
            logic [9:0] ra;
            r  = ($urandom_range(0, 99) < 2);
            s  = ($urandom_range(0, 99) < 30);
            rd = ($urandom_range(0, 99) < 6);
            ra = ($urandom_range(0, 3) == 0) ? 10'(1020 + $urandom_range(0, 3))
                                              : 10'($urandom_range(0, 1023));
            drive(r, s, rd, ra);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 10'h0);
        for (int i = 0; i < 5; i++) step();

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fetch_unit
